// File: rtl/game_sequencer.sv
// Tic-tac-toe move sequencer: validates one-hot submits, tracks the board, detects win/draw.
// Optional per-turn move timeout when MOVE_TIMEOUT_EN is defined.
module game_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic       player,
    output logic [8:0] board_occ,
    output logic [8:0] board_owner,
    output logic [3:0] pos,
    output logic [3:0] move_count,
    output logic       move_ok,
    output logic       move_err,
    output logic       timeout,
    output logic       game_over,
    output logic       win,
    output logic       winner,
    output logic       draw
);

    typedef enum logic [1:0] {WAIT, CHECK, EVAL, OVER} state_t;

    state_t     state_q, state_d;
    logic       s_q;
    logic [2:0] x_q, x_d, y_q, y_d;
    logic       player_q, player_d;
    logic [8:0] occ_q, occ_d, own_q, own_d;
    logic [3:0] pos_q, pos_d, cnt_q, cnt_d;
    logic       ok_q, ok_d, err_q, err_d, to_q, to_d;
    logic       over_q, over_d, win_q, win_d, winner_q, winner_d, draw_q, draw_d;

    logic       submit;
    logic       valid;
    logic [3:0] cell_idx;
    logic [8:0] cell_mask;
    logic [8:0] mine;
    logic       line_hit;
    logic       expire;

    function automatic logic [1:0] oh_idx(input logic [2:0] v);
        case (v)
            3'b001:  oh_idx = 2'd0;
            3'b010:  oh_idx = 2'd1;
            default: oh_idx = 2'd2;
        endcase
    endfunction

    function automatic logic is_oh(input logic [2:0] v);
        is_oh = (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    assign submit    = s & ~s_q;
    assign valid     = is_oh(x_q) & is_oh(y_q);
    assign cell_idx  = 4'(oh_idx(y_q)) * 4'd3 + 4'(oh_idx(x_q));
    assign cell_mask = 9'b1 << cell_idx;

    // Unoccupied cells carry owner 0, so the occ mask keeps them out of P1's set.
    assign mine     = occ_q & (player_q ? own_q : ~own_q);
    assign line_hit = ((mine & 9'h007) == 9'h007) || ((mine & 9'h038) == 9'h038) ||
                      ((mine & 9'h1C0) == 9'h1C0) || ((mine & 9'h049) == 9'h049) ||
                      ((mine & 9'h092) == 9'h092) || ((mine & 9'h124) == 9'h124) ||
                      ((mine & 9'h111) == 9'h111) || ((mine & 9'h054) == 9'h054);

`ifdef MOVE_TIMEOUT_EN
    logic [31:0] tmr_q, tmr_d;

    assign expire = (state_q == WAIT) && (tmr_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmr_d = tmr_q + 32'd1;
        if (state_q != WAIT || submit || expire) tmr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) tmr_q <= '0;
        else       tmr_q <= tmr_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        player_d = player_q;
        occ_d    = occ_q;
        own_d    = own_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        over_d   = over_q;
        win_d    = win_q;
        winner_d = winner_q;
        draw_d   = draw_q;
        case (state_q)
            WAIT: begin
                if (submit) begin
                    x_d     = x;
                    y_d     = y;
                    state_d = CHECK;
                end else if (expire) begin
                    to_d     = 1'b1;
                    player_d = ~player_q;
                end
            end
            CHECK: begin
                if (!valid || (occ_q & cell_mask) != 9'd0) begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                end else begin
                    occ_d   = occ_q | cell_mask;
                    own_d   = player_q ? (own_q | cell_mask) : (own_q & ~cell_mask);
                    pos_d   = cell_idx + 4'd1;
                    cnt_d   = cnt_q + 4'd1;
                    ok_d    = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (line_hit) begin
                    win_d    = 1'b1;
                    winner_d = player_q;
                    over_d   = 1'b1;
                    state_d  = OVER;
                end else if (cnt_q == 4'd9) begin
                    draw_d  = 1'b1;
                    over_d  = 1'b1;
                    state_d = OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = WAIT;
                end
            end
            default: ;
        endcase
    end

    // s_q resets high so a button held through reset does not register as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT;
            s_q      <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            player_q <= 1'b0;
            occ_q    <= '0;
            own_q    <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= 1'b0;
            draw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s;
            x_q      <= x_d;
            y_q      <= y_d;
            player_q <= player_d;
            occ_q    <= occ_d;
            own_q    <= own_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            to_q     <= to_d;
            over_q   <= over_d;
            win_q    <= win_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
        end
    end

    assign player      = player_q;
    assign board_occ   = occ_q;
    assign board_owner = own_q;
    assign pos         = pos_q;
    assign move_count  = cnt_q;
    assign move_ok     = ok_q;
    assign move_err    = err_q;
    assign timeout     = to_q;
    assign game_over   = over_q;
    assign win         = win_q;
    assign winner      = winner_q;
    assign draw        = draw_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a reference board model queues the expected
// outcome of each submit, checked when the move_ok/move_err pulse appears.
module tb_game_sequencer;

    localparam int TO = 16;
`ifdef MOVE_TIMEOUT_EN
    localparam int HOLD = 10;
`else
    localparam int HOLD = 100;
`endif

    logic       clk = 1'b0;
    logic       reset, s;
    logic [2:0] x, y;
    logic       player, move_ok, move_err, timeout, game_over, win, winner, draw;
    logic [8:0] board_occ, board_owner;
    logic [3:0] pos, move_count;

    always #5 clk = ~clk;

    game_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .s(s), .x(x), .y(y),
        .player(player), .board_occ(board_occ), .board_owner(board_owner),
        .pos(pos), .move_count(move_count), .move_ok(move_ok), .move_err(move_err),
        .timeout(timeout), .game_over(game_over), .win(win), .winner(winner), .draw(draw)
    );

    typedef struct {
        bit         ok;
        int         pos;
        logic [8:0] occ;
        logic [8:0] own;
        int         cnt;
        bit         player;
        bit         over;
        bit         win;
        bit         winner;
        bit         draw;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] occ_m, own_m;
    int         pos_m, cnt_m;
    bit         player_m, over_m, win_m, winner_m, draw_m;

    task automatic model_reset();
        occ_m = '0; own_m = '0; pos_m = 0; cnt_m = 0;
        player_m = 0; over_m = 0; win_m = 0; winner_m = 0; draw_m = 0;
    endtask

    function automatic int pos_of(input logic [2:0] xv, input logic [2:0] yv);
        int r = 0;
        int c = 0;
        for (int k = 0; k < 3; k++) begin
            if (xv == (3'b001 << k)) c = k + 1;
            if (yv == (3'b001 << k)) r = k + 1;
        end
        if (r == 0 || c == 0) return 0;
        return 3 * (r - 1) + c;
    endfunction

    function automatic bit line_won(input logic [8:0] occ, input logic [8:0] own, input bit p);
        int L[8][3];
        L = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7}, '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        for (int i = 0; i < 8; i++) begin
            bit all = 1;
            for (int j = 0; j < 3; j++)
                if (!(occ[L[i][j]-1] && own[L[i][j]-1] == p)) all = 0;
            if (all) return 1;
        end
        return 0;
    endfunction

    task automatic do_reset(input logic s_level);
        @(negedge clk);
        reset = 1; s = s_level; x = '0; y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        sb.delete();
    endtask

    task automatic check_reset_vals(input string name);
        logic [35:0] got;
        got = {player, board_occ, board_owner, pos, move_count, move_ok, move_err, timeout,
               game_over, win, winner, draw};
        n_tests++;
        if (got !== 36'd0) begin
            n_fail++;
            $display("FAIL %s outputs=%h expected=%h", name, got, 36'd0);
        end
    endtask

    task automatic press(input logic [2:0] xv, input logic [2:0] yv, input int hold, input string name);
        exp_t e, got;
        int   p;
        int   pulses = 0;
        int   pulse_at = -1;
        int   exp_pulses;
        bit   excl_bad = 0;
        exp_pulses = over_m ? 0 : 1;
        if (!over_m) begin
            p = pos_of(xv, yv);
            if (p == 0 || occ_m[p-1]) begin
                e.ok = 0;
            end else begin
                e.ok = 1;
                occ_m[p-1] = 1'b1;
                own_m[p-1] = player_m;
                cnt_m++;
                pos_m = p;
                if (line_won(occ_m, own_m, player_m)) begin
                    win_m = 1; winner_m = player_m; over_m = 1;
                end else if (cnt_m == 9) begin
                    draw_m = 1; over_m = 1;
                end
            end
            e.pos = pos_m; e.occ = occ_m; e.own = own_m; e.cnt = cnt_m;
            e.over = over_m; e.win = win_m; e.winner = winner_m; e.draw = draw_m;
            if (e.ok && !over_m) player_m = ~player_m;
            e.player = player_m;
            sb.push_back(e);
        end
        @(negedge clk);
        x = xv; y = yv; s = 1;
        @(posedge clk);
        for (int i = 0; i < hold + 4; i++) begin
            @(negedge clk);
            if (i + 1 >= hold) s = 0;
            if (int'(move_ok) + int'(move_err) + int'(timeout) > 1) excl_bad = 1;
`ifndef MOVE_TIMEOUT_EN
            if (timeout !== 1'b0) excl_bad = 1;
`endif
            if (move_ok || move_err) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected pulse ok=%b err=%b at cycle %0d, expected none",
                             name, move_ok, move_err, i);
                end else begin
                    got = sb.pop_front();
                    if ({move_ok, pos, board_occ, board_owner & board_occ, move_count} !==
                        {got.ok, 4'(got.pos), got.occ, got.own & got.occ, 4'(got.cnt)}) begin
                        n_fail++;
                        $display("FAIL %s ok=%b pos=%0d occ=%b own=%b cnt=%0d expected ok=%b pos=%0d occ=%b own=%b cnt=%0d",
                                 name, move_ok, pos, board_occ, board_owner & board_occ, move_count,
                                 got.ok, got.pos, got.occ, got.own & got.occ, got.cnt);
                    end
                end
            end
            if (pulse_at >= 0 && i == pulse_at + 1) begin
                n_tests++;
                if ({player, game_over, win, winner, draw} !==
                    {got.player, got.over, got.win, got.winner, got.draw}) begin
                    n_fail++;
                    $display("FAIL %s_status player/over/win/winner/draw=%b expected %b", name,
                             {player, game_over, win, winner, draw},
                             {got.player, got.over, got.win, got.winner, got.draw});
                end
            end
        end
        n_tests++;
        if (pulses != exp_pulses || (pulses > 0 && pulse_at != 1) || excl_bad) begin
            n_fail++;
            $display("FAIL %s_pulses count=%0d at=%0d excl_bad=%b expected count=%0d at=1 excl_bad=0",
                     name, pulses, pulse_at, excl_bad, exp_pulses);
        end
        n_tests++;
        if ({board_occ, move_count, player, game_over, win, draw} !==
            {occ_m, 4'(cnt_m), player_m, over_m, win_m, draw_m}) begin
            n_fail++;
            $display("FAIL %s_final occ=%b cnt=%0d player=%b over=%b win=%b draw=%b expected occ=%b cnt=%0d player=%b over=%b win=%b draw=%b",
                     name, board_occ, move_count, player, game_over, win, draw,
                     occ_m, cnt_m, player_m, over_m, win_m, draw_m);
        end
    endtask

    task automatic press_pos(input int p, input string name);
        logic [2:0] xv, yv;
        xv = 3'b001 << ((p - 1) % 3);
        yv = 3'b001 << ((p - 1) / 3);
        press(xv, yv, 1, name);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        check_reset_vals("reset_vals");
        repeat (4) @(negedge clk);
        n_tests++;
        if ({move_ok, move_err, move_count} !== 6'd0) begin
            n_fail++;
            $display("FAIL held_through_reset ok=%b err=%b cnt=%0d expected 0 0 0",
                     move_ok, move_err, move_count);
        end
        s = 0;
        @(negedge clk);
    endtask

    task automatic test_win_row();
        press(3'b001, 3'b001, 1, "p1_pos1");
        press(3'b001, 3'b001, 1, "p2_same_cell");
        press(3'b011, 3'b001, 1, "p2_bad_x");
        press(3'b001, 3'b000, 1, "p2_bad_y");
        press_pos(4, "p2_pos4");
        press_pos(2, "p1_pos2");
        press_pos(5, "p2_pos5");
        press_pos(3, "p1_pos3_win");
        n_tests++;
        if ({win, winner, game_over, move_count} !== {1'b1, 1'b0, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL row_win win=%b winner=%b over=%b cnt=%0d expected 1 0 1 5",
                     win, winner, game_over, move_count);
        end
        press_pos(9, "after_win_ignored");
        press(3'b111, 3'b001, 1, "after_win_bad_ignored");
    endtask

    task automatic test_diag_win();
        do_reset(1'b0);
        press_pos(1, "d_p1_1");
        press_pos(2, "d_p2_2");
        press_pos(5, "d_p1_5");
        press_pos(3, "d_p2_3");
        press_pos(9, "d_p1_9_win");
    endtask

    task automatic test_draw();
        int seq[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        do_reset(1'b0);
        foreach (seq[i]) press_pos(seq[i], $sformatf("draw_mv%0d", i));
        n_tests++;
        if ({draw, win, game_over, move_count} !== {1'b1, 1'b0, 1'b1, 4'd9}) begin
            n_fail++;
            $display("FAIL draw_final draw=%b win=%b over=%b cnt=%0d expected 1 0 1 9",
                     draw, win, game_over, move_count);
        end
    endtask

    task automatic test_hold();
        do_reset(1'b0);
        press(3'b010, 3'b010, HOLD, "held_press");
    endtask

    task automatic test_reset_mid_eval();
        do_reset(1'b0);
        press_pos(7, "pre_eval_move");
        @(negedge clk);
        x = 3'b100; y = 3'b010; s = 1;
        @(posedge clk);
        @(negedge clk);
        s = 0;
        @(negedge clk);
        n_tests++;
        if (move_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_eval_pulse move_ok=%b expected 1", move_ok);
        end
        reset = 1;
        @(negedge clk);
        check_reset_vals("reset_in_eval");
        reset = 0;
        model_reset();
        sb.delete();
    endtask

`ifdef MOVE_TIMEOUT_EN
    task automatic test_timeout();
        int seen = -1;
        do_reset(1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                seen = n;
                break;
            end
        end
        n_tests++;
        if (seen != TO) begin
            n_fail++;
            $display("FAIL timeout_latency seen_at=%0d expected %0d", seen, TO);
        end
        @(negedge clk);
        n_tests++;
        if ({player, board_occ, timeout} !== {1'b1, 9'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_effect player=%b occ=%b to=%b expected 1 0 0",
                     player, board_occ, timeout);
        end
    endtask
`else
    task automatic test_timeout();
        bit seen = 0;
        do_reset(1'b0);
        for (int n = 0; n < 3 * TO; n++) begin
            @(negedge clk);
            if (timeout !== 1'b0) seen = 1;
        end
        n_tests++;
        if (seen || player !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout seen=%b player=%b expected 0 0", seen, player);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset = 1; s = 0; x = '0; y = '0;
        model_reset();
        test_reset();
        test_win_row();
        test_diag_win();
        test_draw();
        test_hold();
        test_reset_mid_eval();
        test_timeout();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
